conv_window_streamer: RTL
=========================

# conv_window_streamer

Synthesizable K×K sliding-window generator for the simpleCNN front end. It accepts a raster-order pixel stream under a valid/ready handshake and buffers K image rows. It emits every convolution window, packed in the same IMGIN layout simpleCNN consumes, with its output coordinates. It replaces the behavioural window-feeding done on the bench and adds stride, backpressure and parametrised image/kernel geometry.

## Interface
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, kernel (window) size; K ≤ IMG_W, K ≤ IMG_H
- PIX_W, 8, bits per pixel
- STRIDE, 1, window step in both axes. (IMG_W−K) and (IMG_H−K) must be divisible by STRIDE.
- Derived values:
  - OUT_W = (IMG_W−K)/STRIDE+1, OUT_H = (IMG_H−K)/STRIDE+1
  - CW = max(1, clog2(OUT_W)), RW = max(1, clog2(OUT_H))
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high
- START  in  1  begin frame; sampled only in IDLE
- PIX_VALID  in  1  PIX_IN valid
- PIX_IN  in  PIX_W  pixel, raster order (row-major, column fastest)
- PIX_READY  out  1  pixel accepted when PIX_VALID & PIX_READY
- WIN_VALID  out  1  WIN_* valid
- WIN_READY  in  1  consumer accepts window
- WIN_OUT  out  K*K*PIX_W  window; slice [(i*K+j)*PIX_W +: PIX_W] = pixel(row X*STRIDE+i, col Y*STRIDE+j)
- WIN_X  out  RW  output row index X
- WIN_Y  out  CW  output column index Y
- WIN_LAST  out  1  high with the final window of the frame
- FRAME_DONE  out  1  one-cycle pulse after last window handshake
- BUSY  out  1  high from START acceptance until FRAME_DONE

## Operation
- Storage is a ring of K row buffers, each IMG_W×PIX_W. A row pointer tracks the oldest row.
- FSM states are IDLE, LOAD, EMIT and DONE.
- IDLE:
  - PIX_READY=0; BUSY=0.
  - START=1 → LOAD; clear row and column counters and output indices.
- LOAD:
  - PIX_READY=1. Each handshake writes PIX_IN to the current row/column and advances the column; the row advances at IMG_W−1.
  - First output row needs K complete rows. Each later output row needs STRIDE new rows, which overwrite the oldest STRIDE buffers.
  - When the needed row count is reached, go to EMIT with Y=0.
- EMIT:
  - PIX_READY=0. The window for (X,Y) is registered on WIN_OUT/WIN_X/WIN_Y with WIN_VALID=1.
  - On WIN_VALID & WIN_READY: if Y<OUT_W−1, increment Y and register the next window.
  - Otherwise Y=0. If X<OUT_H−1, increment X and go to LOAD. If X=OUT_H−1, go to DONE.
- DONE: FRAME_DONE=1 for one cycle; go to IDLE.
- Input rows that no window needs are never requested. With legal parameters, every row is consumed by the final emit.
- Window order is X outer, Y inner. A frame yields exactly OUT_H*OUT_W windows (576 at defaults).
- WIN_LAST=1 exactly when X=OUT_H−1 and Y=OUT_W−1 while WIN_VALID=1.
- Outputs hold their values while WIN_VALID=1 and WIN_READY=0 (AXI-style; never retracted).

## Timing
- Reset: next edge with RST=1 forces IDLE. Outputs reset to PIX_READY=0, WIN_VALID=0, WIN_OUT=0, WIN_X=0, WIN_Y=0, WIN_LAST=0, FRAME_DONE=0, BUSY=0.
- Reset mid-frame discards the partial frame; buffer contents need not be cleared.
- START is sampled in IDLE; BUSY and PIX_READY rise on the next cycle.
- START while BUSY is ignored. START held high re-arms immediately after DONE→IDLE.
- First WIN_VALID rises the cycle after the handshake of pixel number K*IMG_W.
- Throughput is one window per cycle while WIN_READY=1. The next window is valid the cycle after a handshake.
- From the last window handshake of a row to the next LOAD: one cycle. The first window of the next row is valid one cycle after its final required pixel.
- FRAME_DONE asserts the cycle after the WIN_LAST handshake. BUSY falls in the same cycle as FRAME_DONE deasserts.
- PIX_VALID gaps stall LOAD with no state loss. PIX_VALID while PIX_READY=0 is ignored.

## Test plan
- Defaults, ramp input pixel(r,c)=(r*28+c) mod 256, WIN_READY=1:
  - 576 windows in X-major order.
  - Window (0,0): slice 0=0x00, slice 24=0x74.
  - Window (23,23): slice 0=(23*28+23) mod 256=0x9B.
  - WIN_LAST only on (23,23); single FRAME_DONE pulse; first WIN_VALID the cycle after the 140th accept.
- Random WIN_READY backpressure (50%) and random PIX_VALID gaps: same 576 windows bit-exact vs model; WIN_* stable while stalled.
- IMG_W=IMG_H=9, K=3, STRIDE=2: 16 windows; window (1,2) slice 0 = pixel(2,4); X,Y widths = 2 bits.
- RST asserted after 200 accepts, then START: fresh frame correct from (0,0); no stale window emitted.
- START pulsed during EMIT: ignored, window count unchanged. START held high: two back-to-back frames, 1152 windows, two FRAME_DONE pulses.

Source files
------------

// File: rtl/conv_window_streamer_if.sv
// Handshake bundle for conv_window_streamer: pixel input stream, window output
// stream and frame control, with the streamer as slave and its driver as master.
interface conv_window_streamer_if #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int PIX_W  = 8,
    parameter int STRIDE = 1
);
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam int CW    = ($clog2(OUT_W) < 1) ? 1 : $clog2(OUT_W);
    localparam int RW    = ($clog2(OUT_H) < 1) ? 1 : $clog2(OUT_H);

    logic                 START;
    logic                 PIX_VALID;
    logic [PIX_W-1:0]     PIX_IN;
    logic                 PIX_READY;
    logic                 WIN_VALID;
    logic                 WIN_READY;
    logic [K*K*PIX_W-1:0] WIN_OUT;
    logic [RW-1:0]        WIN_X;
    logic [CW-1:0]        WIN_Y;
    logic                 WIN_LAST;
    logic                 FRAME_DONE;
    logic                 BUSY;

    modport slave (
        input  START, PIX_VALID, PIX_IN, WIN_READY,
        output PIX_READY, WIN_VALID, WIN_OUT, WIN_X, WIN_Y, WIN_LAST, FRAME_DONE, BUSY
    );

    modport master (
        output START, PIX_VALID, PIX_IN, WIN_READY,
        input  PIX_READY, WIN_VALID, WIN_OUT, WIN_X, WIN_Y, WIN_LAST, FRAME_DONE, BUSY
    );
endinterface

// File: rtl/conv_window_streamer.sv
// K x K sliding-window generator: buffers K image rows in a ring and emits every
// strided window of a raster-order frame under valid/ready backpressure.
module conv_window_streamer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int PIX_W  = 8,
    parameter int STRIDE = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    conv_window_streamer_if.slave   bus
);
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam int CW    = ($clog2(OUT_W) < 1) ? 1 : $clog2(OUT_W);
    localparam int RW    = ($clog2(OUT_H) < 1) ? 1 : $clog2(OUT_H);
    localparam int CLW   = ($clog2(IMG_W) < 1) ? 1 : $clog2(IMG_W);
    localparam int SW    = ($clog2(K) < 1) ? 1 : $clog2(K);
    localparam int RLMAX = (K > STRIDE) ? K : STRIDE;
    localparam int RLW   = $clog2(RLMAX + 1);
    localparam int WW    = K * K * PIX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CLW-1:0] COL_LAST  = CLW'(IMG_W - 1);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(K - 1);
    localparam logic [RW-1:0]  X_LAST    = RW'(OUT_H - 1);
    localparam logic [CW-1:0]  Y_LAST    = CW'(OUT_W - 1);

    logic [1:0]       state_q, state_d;
    logic [CLW-1:0]   col_q, col_d;
    logic [CLW-1:0]   y_col_q, y_col_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [RLW-1:0]   rows_left_q, rows_left_d;
    logic [RW-1:0]    x_q, x_d;
    logic [CW-1:0]    y_q, y_d;
    logic             pix_ready_q, pix_ready_d;
    logic             win_valid_q, win_valid_d;
    logic             win_last_q, win_last_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;
    logic [WW-1:0]    win_q, win_d;
    logic [WW-1:0]    win_next_s;
    logic             load_win_s;
    logic             wr_en_s;
    logic [SW:0]      slot_sum_s;
    logic [SW-1:0]    rd_slot_s;
    logic [CLW-1:0]   rd_col_s;

    logic [PIX_W-1:0] row_buf_q [K][IMG_W];

    assign wr_en_s = pix_ready_q & bus.PIX_VALID;

    // Frame sequencing: row loading, window stepping and handshake control.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        slot_d       = slot_q;
        rows_left_d  = rows_left_q;
        x_d          = x_q;
        y_d          = y_q;
        y_col_d      = y_col_q;
        pix_ready_d  = pix_ready_q;
        win_valid_d  = win_valid_q;
        win_last_d   = win_last_q;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        load_win_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d     = S_LOAD;
                    col_d       = '0;
                    slot_d      = '0;
                    rows_left_d = RLW'(K);
                    x_d         = '0;
                    y_d         = '0;
                    y_col_d     = '0;
                    pix_ready_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (wr_en_s && (col_q == COL_LAST)) begin
                    col_d       = '0;
                    slot_d      = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
                    rows_left_d = rows_left_q - RLW'(1);
                    if (rows_left_q == RLW'(1)) begin
                        state_d     = S_EMIT;
                        pix_ready_d = 1'b0;
                        win_valid_d = 1'b1;
                        load_win_s  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else if (wr_en_s) begin
                    col_d = col_q + CLW'(1);
                end else begin
                    col_d = col_q;
                end
            end
            S_EMIT: begin
                if (win_valid_q && bus.WIN_READY) begin
                    if (y_q != Y_LAST) begin
                        y_d        = y_q + CW'(1);
                        y_col_d    = y_col_q + CLW'(STRIDE);
                        load_win_s = 1'b1;
                    end else begin
                        y_d         = '0;
                        y_col_d     = '0;
                        win_valid_d = 1'b0;
                        win_last_d  = 1'b0;
                        if (x_q != X_LAST) begin
                            x_d         = x_q + RW'(1);
                            state_d     = S_LOAD;
                            rows_left_d = RLW'(STRIDE);
                            pix_ready_d = 1'b1;
                        end else begin
                            state_d      = S_DONE;
                            frame_done_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                pix_ready_d = 1'b0;
                win_valid_d = 1'b0;
            end
        endcase
        if (load_win_s) begin
            win_last_d = (x_d == X_LAST) && (y_d == Y_LAST);
            win_d      = win_next_s;
        end else begin
            win_d = win_q;
        end
    end

    // Gather the next window; the pixel being written this cycle is forwarded
    // so the first window of a row can launch on its final pixel.
    always_comb begin
        win_next_s = '0;
        slot_sum_s = '0;
        rd_slot_s  = '0;
        rd_col_s   = '0;
        for (int i = 0; i < K; i++) begin
            slot_sum_s = {1'b0, slot_d} + (SW+1)'(i);
            if (slot_sum_s >= (SW+1)'(K)) begin
                rd_slot_s = SW'(slot_sum_s - (SW+1)'(K));
            end else begin
                rd_slot_s = slot_sum_s[SW-1:0];
            end
            for (int j = 0; j < K; j++) begin
                rd_col_s = y_col_d + CLW'(j);
                if (wr_en_s && (rd_slot_s == slot_q) && (rd_col_s == col_q)) begin
                    win_next_s[(i*K+j)*PIX_W +: PIX_W] = bus.PIX_IN;
                end else begin
                    win_next_s[(i*K+j)*PIX_W +: PIX_W] = row_buf_q[rd_slot_s][rd_col_s];
                end
            end
        end
    end

    // Row ring storage; contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            row_buf_q[slot_q][col_q] <= bus.PIX_IN;
        end
    end

    // Control and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            y_col_q      <= '0;
            slot_q       <= '0;
            rows_left_q  <= '0;
            x_q          <= '0;
            y_q          <= '0;
            pix_ready_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            win_q        <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            y_col_q      <= y_col_d;
            slot_q       <= slot_d;
            rows_left_q  <= rows_left_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_ready_q  <= pix_ready_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            win_q        <= win_d;
        end
    end

    assign bus.PIX_READY  = pix_ready_q;
    assign bus.WIN_VALID  = win_valid_q;
    assign bus.WIN_OUT    = win_q;
    assign bus.WIN_X      = x_q;
    assign bus.WIN_Y      = y_q;
    assign bus.WIN_LAST   = win_last_q;
    assign bus.FRAME_DONE = frame_done_q;
    assign bus.BUSY       = busy_q;
endmodule
